// File: rtl/div_bcd_display_pkg.sv
// div_bcd_display_pkg: FSM states, width limit and seven-segment codes shared by the BCD display block
package div_bcd_display_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int MAX_WIDTH = 6;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h40;
endpackage

// File: rtl/div_bcd_display_seg7_decoder.sv
// seg7_decoder: digit(4)+blank -> seg(7) {g,f,e,d,c,b,a} active-high, non-decimal shows dash, blank wins
module seg7_decoder
  import div_bcd_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    if (blank) seg = SEG_BLANK;
  end
endmodule

// File: rtl/div_bcd_display.sv
// div_bcd_display: in_valid/in_data captured -> double-dabble -> bcd_valid/bcd_tens/bcd_ones, busy, muxed 2-digit seg/an
module div_bcd_display
  import div_bcd_display_pkg::*;
#(
  parameter int WIDTH        = 5,
  parameter int REFRESH_BITS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             busy,
  output logic             bcd_valid,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic [6:0]       seg,
  output logic [1:0]       an
);
  localparam int SW = WIDTH + 8;
  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("div_bcd_display: WIDTH must be 1..%0d", MAX_WIDTH);
  end
  if (REFRESH_BITS < 1) begin : g_refresh_check
    $error("div_bcd_display: REFRESH_BITS must be at least 1");
  end
  state_t state, state_n;
  logic [SW-1:0] sr, sr_n, adj;
  logic [2:0] cnt, cnt_n;
  logic [3:0] tens_n, ones_n;
  logic valid_n;
  logic [REFRESH_BITS-1:0] rcnt;
  logic sel;
  // BCD nibbles sit above the binary bits; after WIDTH shifts the binary part is fully consumed
  always_comb begin
    adj = sr;
    adj[SW-1:SW-4] = sr[SW-1:SW-4] + (sr[SW-1:SW-4] >= 4'd5 ? 4'd3 : 4'd0);
    adj[SW-5:SW-8] = sr[SW-5:SW-8] + (sr[SW-5:SW-8] >= 4'd5 ? 4'd3 : 4'd0);
    state_n = state;
    sr_n = sr;
    cnt_n = cnt;
    tens_n = bcd_tens;
    ones_n = bcd_ones;
    valid_n = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        sr_n = {8'b0, in_data};
        cnt_n = 3'(WIDTH);
        state_n = SHIFT;
      end
      SHIFT: begin
        sr_n = adj << 1;
        cnt_n = cnt - 3'd1;
        state_n = cnt == 3'd1 ? DONE : SHIFT;
      end
      DONE: begin
        tens_n = sr[SW-1:SW-4];
        ones_n = sr[SW-5:SW-8];
        valid_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      bcd_tens <= '0;
      bcd_ones <= '0;
      bcd_valid <= 1'b0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      cnt <= cnt_n;
      bcd_tens <= tens_n;
      bcd_ones <= ones_n;
      bcd_valid <= valid_n;
    end
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt <= '0;
      sel <= 1'b0;
    end else begin
      rcnt <= rcnt + 1'b1;
      if (&rcnt) sel <= ~sel;
    end
  end
  assign an = sel ? 2'b10 : 2'b01;
  seg7_decoder u_dec (
    .digit(sel ? bcd_tens : bcd_ones),
    .blank(sel && bcd_tens == 4'd0),
    .seg  (seg)
  );
endmodule
